// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states,
// parity-mode constants and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest legal payload; narrower payloads are zero-extended, which
    // leaves their XOR unchanged.
    localparam int unsigned MAX_DATA_BITS = 9;

    function automatic logic data_parity(input logic [MAX_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver result bundle towards the frame parser.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_rx_data;
    logic                 o_rx_done;
    logic                 o_rx_busy;
    logic                 o_parity_err;
    logic                 o_frame_err;

    modport master (
        output o_rx_data, o_rx_done, o_rx_busy, o_parity_err, o_frame_err
    );

    modport slave (
        input  o_rx_data, o_rx_done, o_rx_busy, o_parity_err, o_frame_err
    );
endinterface

// File: rtl/uart_rx_sync_vote.sv
// RX line synchroniser plus 3-sample majority vote over baud ticks.
module uart_rx_sync_vote (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic rx,
    output logic rx_s,
    output logic vote
);
    logic       rx_meta;
    logic [1:0] hist;

    // Two-flop synchroniser; history captures rx_s on every baud tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            hist    <= '1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            if (tick)
                hist <= {hist[0], rx_s};
        end
    end

    // On a tick edge the two stored samples plus the live rx_s form the
    // window of the current and two previous ticks.
    always_comb begin
        vote = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, oversampling, parity and
// stop bits, with majority voting, false-start rejection and break holdoff.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic baud_rate_tick,
    input  logic RX,
    uart_rx_param_if.master rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_VOTE    = TW'(M + 1);
    localparam logic [3:0]    B_LAST    = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic rx_s, vote;

    rx_state_e            state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [3:0]           bit_cnt, bit_n;
    logic                 stop_cnt, stop_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n, ferr, ferr_n, holdoff, holdoff_n;
    logic                 load, exp_par;
    logic [MAX_DATA_BITS-1:0] par_vec;

    logic [DATA_BITS-1:0] data_q;
    logic                 done_q, busy_q, perr_q, ferr_q;

    uart_rx_sync_vote u_sync (
        .clk   (clk),
        .reset (reset),
        .tick  (baud_rate_tick),
        .rx    (RX),
        .rx_s  (rx_s),
        .vote  (vote)
    );

    // Next-state and datapath decisions, evaluated only on baud ticks.
    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt;
        bit_n     = bit_cnt;
        stop_n    = stop_cnt;
        shreg_n   = shreg;
        perr_n    = perr;
        ferr_n    = ferr;
        holdoff_n = holdoff;
        load      = 1'b0;
        par_vec   = '0;
        par_vec[DATA_BITS-1:0] = shreg;
        exp_par   = data_parity(par_vec) ^ PAR_MODE;

        if (baud_rate_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s && !holdoff) begin
                        state_n = ST_START;
                        tick_n  = '0;
                        bit_n   = '0;
                        stop_n  = 1'b0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                    end else if (rx_s) begin
                        holdoff_n = 1'b0;
                    end
                end
                ST_START: begin
                    tick_n = tick_cnt + 1'b1;
                    if (tick_cnt == T_VOTE && vote) begin
                        state_n = ST_IDLE;
                        tick_n  = '0;
                    end else if (tick_cnt == T_LAST) begin
                        state_n = ST_DATA;
                        tick_n  = '0;
                    end
                end
                ST_DATA: begin
                    tick_n = tick_cnt + 1'b1;
                    if (tick_cnt == T_VOTE)
                        shreg_n = {vote, shreg[DATA_BITS-1:1]};
                    if (tick_cnt == T_LAST) begin
                        tick_n = '0;
                        if (bit_cnt == B_LAST)
                            state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        else
                            bit_n = bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    tick_n = tick_cnt + 1'b1;
                    if (tick_cnt == T_VOTE && vote != exp_par)
                        perr_n = 1'b1;
                    if (tick_cnt == T_LAST) begin
                        state_n = ST_STOP;
                        tick_n  = '0;
                    end
                end
                ST_STOP: begin
                    tick_n = tick_cnt + 1'b1;
                    if (tick_cnt == T_VOTE) begin
                        if (!vote)
                            ferr_n = 1'b1;
                        // Leaving half a bit early lets back-to-back frames
                        // resynchronise on the next start edge.
                        if (stop_cnt == STOP_LAST) begin
                            state_n   = ST_IDLE;
                            tick_n    = '0;
                            load      = 1'b1;
                            holdoff_n = ferr | ~vote;
                        end
                    end else if (tick_cnt == T_LAST) begin
                        stop_n = 1'b1;
                        tick_n = '0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            holdoff  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            shreg    <= shreg_n;
            perr     <= perr_n;
            ferr     <= ferr_n;
            holdoff  <= holdoff_n;
            done_q   <= load;
            busy_q   <= (state_n != ST_IDLE);
            if (load) begin
                data_q <= shreg;
                perr_q <= perr;
                ferr_q <= ferr_n;
            end
        end
    end

    assign rx_if.o_rx_data    = data_q;
    assign rx_if.o_rx_done    = done_q;
    assign rx_if.o_rx_busy    = busy_q;
    assign rx_if.o_parity_err = perr_q;
    assign rx_if.o_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E1 instance driven with
// directed frames; a frame-level expectation queue is checked every cycle.
module tb_uart_rx_param;

    localparam int OS = 16;
    localparam int M  = OS / 2;
    // Bench bit boundaries lead the receiver's bit counter by one tick, so
    // this offset lands on the receiver's middle vote sample.
    localparam int GLITCH_OFS = M + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic [1:0] div = '0;
    logic tick;
    logic rst_q = 1'b1;

    int nchecks = 0;
    int nerr = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] last_d[2];
    logic       last_pe[2];
    logic       last_fe[2];
    logic       prev_busy[2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div   <= div + 2'd1;
        rst_q <= reset;
    end
    assign tick = (div == 2'd0);

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .reset(reset), .baud_rate_tick(tick), .RX(rx0), .rx_if(if0)
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .reset(reset), .baud_rate_tick(tick), .RX(rx1), .rx_if(if1)
    );

    task automatic chk(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", idx, name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int idx, input logic done, input logic busy,
                       input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        if (rst_q) begin
            chk(idx, "reset_data", 32'(d), 32'h0);
            chk(idx, "reset_done", 32'(done), 32'h0);
            chk(idx, "reset_busy", 32'(busy), 32'h0);
            chk(idx, "reset_perr", 32'(pe), 32'h0);
            chk(idx, "reset_ferr", 32'(fe), 32'h0);
            last_d[idx]  = '0;
            last_pe[idx] = 1'b0;
            last_fe[idx] = 1'b0;
        end else if (done) begin
            chk(idx, "busy_at_done", 32'(busy), 32'h0);
            chk(idx, "busy_before_done", 32'(prev_busy[idx]), 32'h1);
            if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
                nchecks++;
                nerr++;
                $display("FAIL dut%0d unexpected_done: got data %0h expected no frame", idx, d);
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                chk(idx, "frame_data", 32'(d), 32'(e.d));
                chk(idx, "frame_perr", 32'(pe), 32'(e.pe));
                chk(idx, "frame_ferr", 32'(fe), 32'(e.fe));
                last_d[idx]  = e.d;
                last_pe[idx] = e.pe;
                last_fe[idx] = e.fe;
            end
        end else begin
            chk(idx, "hold_data", 32'(d), 32'(last_d[idx]));
            chk(idx, "hold_perr", 32'(pe), 32'(last_pe[idx]));
            chk(idx, "hold_ferr", 32'(fe), 32'(last_fe[idx]));
        end
        prev_busy[idx] = busy;
    endtask

    // Single compare process for both receivers.
    always @(negedge clk) begin
        cmp(0, if0.o_rx_done, if0.o_rx_busy, if0.o_rx_data, if0.o_parity_err, if0.o_frame_err);
        cmp(1, if1.o_rx_done, if1.o_rx_busy, if1.o_rx_data, if1.o_parity_err, if1.o_frame_err);
    end

    task automatic next_tick();
        do @(posedge clk); while (tick !== 1'b1);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    task automatic set_rx(input int idx, input logic v);
        if (idx == 0) rx0 = v;
        else rx1 = v;
    endtask

    // Drive one frame, bit by bit for OS ticks each. abort_bits>0 stops
    // after that many line bits; push queues the expected outcome.
    task automatic send_frame(input int idx, input logic [7:0] data, input logic par_en,
                              input logic par_bit, input logic stop_lvl,
                              input int glitch_bit, input int abort_bits, input logic push);
        logic bits[11];
        int   n;
        exp_t e;
        logic v;
        n = 0;
        bits[n++] = 1'b0;
        for (int i = 0; i < 8; i++) bits[n++] = data[i];
        if (par_en) bits[n++] = par_bit;
        bits[n++] = stop_lvl;
        if (push) begin
            e.d  = data;
            e.pe = par_en && (par_bit != (^data));
            e.fe = !stop_lvl;
            if (idx == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            if (abort_bits > 0 && b == abort_bits) return;
            for (int t = 0; t < OS; t++) begin
                v = bits[b];
                if (b - 1 == glitch_bit && t == GLITCH_OFS) v = ~v;
                set_rx(idx, v);
                next_tick();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            last_d[i] = '0; last_pe[i] = 1'b0; last_fe[i] = 1'b0; prev_busy[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_ticks(20);

        // Plain 8N1 frame.
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        wait_ticks(4);
        chk(0, "a5_data", 32'(if0.o_rx_data), 32'hA5);
        chk(0, "a5_ferr", 32'(if0.o_frame_err), 32'h0);

        // False start: 4 ticks low, then high.
        set_rx(0, 1'b0);
        wait_ticks(3);
        chk(0, "false_start_busy", 32'(if0.o_rx_busy), 32'h1);
        wait_ticks(1);
        set_rx(0, 1'b1);
        wait_ticks(20);
        chk(0, "false_start_idle", 32'(if0.o_rx_busy), 32'h0);
        chk(0, "false_start_data", 32'(if0.o_rx_data), 32'hA5);

        // Even parity: 0x37 has five ones, so the correct parity bit is 1.
        send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1, -1, 0, 1'b1);
        wait_ticks(4);
        chk(1, "par_bad_data", 32'(if1.o_rx_data), 32'h37);
        chk(1, "par_bad_perr", 32'(if1.o_parity_err), 32'h1);
        send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1, -1, 0, 1'b1);
        wait_ticks(4);
        chk(1, "par_ok_perr", 32'(if1.o_parity_err), 32'h0);

        // Break: all-low frame, line held low 40 bit-times, then recovery.
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0, -1, 0, 1'b1);
        chk(0, "break_ferr", 32'(if0.o_frame_err), 32'h1);
        chk(0, "break_data", 32'(if0.o_rx_data), 32'h00);
        wait_ticks(40 * OS);
        chk(0, "break_holdoff_idle", 32'(if0.o_rx_busy), 32'h0);
        set_rx(0, 1'b1);
        wait_ticks(20);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        wait_ticks(4);
        chk(0, "after_break_data", 32'(if0.o_rx_data), 32'h5A);
        chk(0, "after_break_ferr", 32'(if0.o_frame_err), 32'h0);

        // Single-tick glitch on data bit 3 of 0xF0.
        send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 3, 0, 1'b1);
        wait_ticks(4);
        chk(0, "glitch_data", 32'(if0.o_rx_data), 32'hF0);

        // Back-to-back frames, then reset in the middle of a third.
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        chk(0, "b2b_data", 32'(if0.o_rx_data), 32'hAA);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 4, 1'b0);
        chk(0, "abort_busy_pre", 32'(if0.o_rx_busy), 32'h1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        set_rx(0, 1'b1);
        reset = 1'b0;
        wait_ticks(40);
        chk(0, "abort_data", 32'(if0.o_rx_data), 32'h00);
        chk(0, "abort_busy", 32'(if0.o_rx_busy), 32'h0);

        chk(0, "pending_frames", 32'(q0.size()), 32'h0);
        chk(1, "pending_frames", 32'(q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
